// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle ripple adder that adds two WIDTH-bit operands
// plus a carry-in, CHUNK bits per clock. It uses full_adder as the per-bit cell
// and has valid/ready handshakes on both the operand side and the result side.

// One-bit full adder cell. It is instantiated CHUNK times to form the chunk slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] chunk_sum;
  logic [CHUNK:0]   chain;

  // Pick the operand slice selected by the chunk index; only the slice that matches the index is used
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  assign chain[0] = carry_q;

  for (genvar g = 0; g < CHUNK; g++) begin : g_fa
    full_adder u_fa (
      .a    (a_chunk[g]),
      .b    (b_chunk[g]),
      .cin  (chain[g]),
      .sum  (chunk_sum[g]),
      .cout (chain[g+1])
    );
  end

  // Next-state logic: handle the accept, step through one chunk per ADD cycle, then hold in DONE until the result is taken
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          sum_d   = '0;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*CHUNK +: CHUNK] = chunk_sum;
          end
        end
        carry_d = chain[CHUNK];
        if (idx_q == IDX_W'(N - 1)) begin
          cout_d  = chain[CHUNK];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; a synchronous reset discards any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle ripple adder: adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, using the full_adder bit cell as the per-bit primitive.
- Valid/ready handshake on input and output sides. Sits between operand registers and a result consumer in the datapath.
- Extends the single-bit full adder with width generalisation, carry chaining across cycles, a signed-overflow flag and backpressure.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH.
- N (localparam) = WIDTH/CHUNK, number of ADD cycles per operation.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH
- cout  out  1  unsigned carry-out of the MSB
- overflow  out  1  two's-complement overflow

Behaviour:
- Reset (rst_n low at a rising edge)
  - State becomes IDLE; chunk index = 0.
  - Outputs: in_ready = 1, out_valid = 0, sum = 0, cout = 0, overflow = 0.
  - Reset takes priority over all other events, including mid-ADD and mid-DONE; in-flight operation is discarded.
- FSM states: IDLE, ADD, DONE.
- IDLE
  - in_ready = 1, out_valid = 0.
  - Transfer occurs on an edge where in_valid && in_ready: capture a, b, cin into internal registers; clear the sum register; idx = 0; next state ADD.
- ADD
  - in_ready = 0.
  - Each edge adds bits [idx*CHUNK +: CHUNK] of the captured a and b plus the running carry (initial carry = captured cin). The result is written to the same slice of sum, and the chunk carry-out is registered as the running carry. idx increments.
  - On the edge processing idx = N-1:
    - cout = final carry.
    - overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]).
    - out_valid = 1; next state DONE.
- Latency: out_valid is visible after exactly N edges following the accepting edge. With CHUNK = WIDTH, this is 1 edge.
- DONE
  - out_valid = 1, in_ready = 0.
  - sum, cout and overflow are held stable for as long as out_ready = 0.
  - On an edge with out_ready = 1: out_valid = 0, next state IDLE, in_ready = 1 on the following cycle. There is no same-cycle re-accept.
  - sum, cout and overflow retain their last values after leaving DONE until the next operation clears sum at its accepting edge.
- Inputs a, b and cin are ignored outside the accepting edge; changes during ADD or DONE do not affect the result.
- in_valid held high while in_ready = 0 has no effect; the operand is accepted only on a later IDLE edge.
- Intermediate sum values during ADD are not valid; consumers sample only when out_valid = 1.
- Only a single operation is in flight at a time; there is no pipelining.

Test Plan:
- WIDTH=16, CHUNK=4: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0; out_valid rises exactly 4 edges after the accepting edge.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, overflow=1. Then a=0x0FFF, b=0x0000, cin=1 -> sum=0x1000, cout=0, overflow=0, confirming carry crosses chunk boundaries.
- Backpressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 and new operands -> sum/cout/overflow stable, in_ready=0, and the new operands are not accepted until the cycle after the out_ready=1 edge.
- Reset mid-operation: assert rst_n=0 at the 2nd ADD edge -> next cycle in_ready=1, out_valid=0, sum=0. A following op with a=0x1234, b=0x4321 completes with sum=0x5555.
- CHUNK=16 instance: a=0x8000, b=0x8000, cin=1 -> sum=0x0001, cout=1, overflow=1, latency 1 edge.
- Self-checking random run: 1000 operations with random a/b/cin and random out_ready; each result is compared against a behavioural model ({cout,sum} = a+b+cin; overflow per the rule above); the bench calls $error on mismatch.
